// File: rtl/iter_divider.sv
// Iterative restoring divider producing one quotient bit per RUN cycle.
// Define ITER_DIVIDER_SIGNED_EN to enable two's-complement division via signed_op.
module iter_divider #(
   parameter  int N  = 16,
   localparam int CW = $clog2(N + 1)
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         req,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   input  logic         signed_op,
   output logic [N-1:0] q,
   output logic [N-1:0] r,
   output logic         busy,
   output logic         ready,
   output logic         exception
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  dvs_q, dvs_d;
   logic [N-1:0]  quo_q, quo_d;
   logic [N-1:0]  rem_q, rem_d;
   logic [N-1:0]  q_q, q_d;
   logic [N-1:0]  r_q, r_d;
   logic          busy_q, busy_d;
   logic          ready_q, ready_d;
   logic          exc_q, exc_d;
   logic          dz_q, dz_d;

   logic [N:0]    rem_sh;
   logic [N+1:0]  diff;
   logic [N-1:0]  a_mag, b_mag;
   logic [N-1:0]  quo_fin, rem_fin;
   logic          unused_bits;

`ifdef ITER_DIVIDER_SIGNED_EN
   logic qneg_q, qneg_d;
   logic rneg_q, rneg_d;
   logic a_neg, b_neg;

   assign a_neg   = signed_op & dividend[N-1];
   assign b_neg   = signed_op & divisor[N-1];
   assign a_mag   = a_neg ? -dividend : dividend;
   assign b_mag   = b_neg ? -divisor : divisor;
   assign quo_fin = qneg_q ? -quo_q : quo_q;
   assign rem_fin = rneg_q ? -rem_q : rem_q;
   assign unused_bits = diff[N];
`else
   assign a_mag   = dividend;
   assign b_mag   = divisor;
   assign quo_fin = quo_q;
   assign rem_fin = rem_q;
   assign unused_bits = diff[N] ^ signed_op;
`endif

   // quo_q holds the remaining dividend bits and collects quotient bits
   assign rem_sh = {rem_q, quo_q[N-1]};
   assign diff   = {1'b0, rem_sh} - {2'b00, dvs_q};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvs_d   = dvs_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      q_d     = q_q;
      r_d     = r_q;
      busy_d  = busy_q;
      ready_d = 1'b0;
      exc_d   = exc_q;
      dz_d    = dz_q;
`ifdef ITER_DIVIDER_SIGNED_EN
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (req) begin
               busy_d = 1'b1;
               cnt_d  = '0;
               if (divisor == '0) begin
                  dz_d    = 1'b1;
                  quo_d   = '1;
                  rem_d   = dividend;
`ifdef ITER_DIVIDER_SIGNED_EN
                  qneg_d  = 1'b0;
                  rneg_d  = 1'b0;
`endif
                  state_d = DONE;
               end else begin
                  dz_d    = 1'b0;
                  exc_d   = 1'b0;
                  quo_d   = a_mag;
                  dvs_d   = b_mag;
                  rem_d   = '0;
`ifdef ITER_DIVIDER_SIGNED_EN
                  qneg_d  = a_neg ^ b_neg;
                  rneg_d  = a_neg;
`endif
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            quo_d = {quo_q[N-2:0], ~diff[N+1]};
            rem_d = diff[N+1] ? rem_sh[N-1:0] : diff[N-1:0];
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) state_d = DONE;
         end
         DONE: begin
            q_d     = quo_fin;
            r_d     = rem_fin;
            exc_d   = dz_q;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dvs_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
         exc_q   <= 1'b0;
         dz_q    <= 1'b0;
`ifdef ITER_DIVIDER_SIGNED_EN
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvs_q   <= dvs_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         q_q     <= q_d;
         r_q     <= r_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
         exc_q   <= exc_d;
         dz_q    <= dz_d;
`ifdef ITER_DIVIDER_SIGNED_EN
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
`endif
      end
   end

   assign q         = q_q;
   assign r         = r_q;
   assign busy      = busy_q;
   assign ready     = ready_q;
   assign exception = exc_q;

endmodule

// File: doc/iter_divider.md
ITER_DIVIDER -- requirements
Module: iter_divider

Interface
REQ-001 SHALL provide parameter: N, 16, operand/result width in bits (legal range 4..64).
REQ-002 SHALL provide parameter: CW, $clog2(N+1), iteration counter width (derived, not overridden).
REQ-003 SHALL provide port: clk  input  1  rising-edge clock.
REQ-004 SHALL provide port: rstn  input  1  asynchronous active-low reset.
REQ-005 SHALL provide port: req  input  1  request; sampled only in IDLE.
REQ-006 SHALL provide port: dividend  input  N  numerator.
REQ-007 SHALL provide port: divisor  input  N  denominator.
REQ-008 SHALL provide port: signed_op  input  1  signed-mode select, sampled with req.
REQ-009 SHALL provide port: q  output  N  quotient.
REQ-010 SHALL provide port: r  output  N  remainder.
REQ-011 SHALL provide port: busy  output  1  high from accept until the cycle ready asserts.
REQ-012 SHALL provide port: ready  output  1  one-cycle result-valid pulse.
REQ-013 SHALL provide port: exception  output  1  divide-by-zero flag, valid with ready.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 IDLE: req=1 with divisor!=0 SHALL latch operands and signed_op, clear counter, set busy, go RUN.
REQ-016 IDLE: req=1 with divisor==0 SHALL go DONE with exception=1, q=all ones, r=dividend; no RUN cycles.
REQ-017 RUN SHALL perform one restoring shift-subtract step per cycle on magnitudes, exactly N cycles, then go DONE.
REQ-018 DONE SHALL drive ready=1 for exactly one cycle, clear busy, return to IDLE.
REQ-019 Latency: accept on edge 0 SHALL yield ready high after edge N+1; divide-by-zero SHALL yield ready after edge 1.
REQ-020 q, r, exception SHALL hold their values from the ready pulse until the next accepted req.
REQ-021 req while busy SHALL be ignored; operand changes after accept SHALL not affect the result.
REQ-022 req in the DONE cycle SHALL be ignored; req in the following IDLE cycle SHALL be accepted (back-to-back throughput N+2 cycles).
REQ-023 Unsigned: q=floor(dividend/divisor), r=dividend-q*divisor, both exact in N bits.
REQ-024 Remainder SHALL always satisfy |r| < |divisor| for non-exception results.
REQ-025 exception SHALL be cleared on the next accepted non-zero-divisor request.

Reset
REQ-026 rstn low SHALL immediately force IDLE, q=0, r=0, busy=0, ready=0, exception=0, counter=0.
REQ-027 Reset asserted mid-RUN SHALL abort the operation with no ready pulse after release.
REQ-028 First req SHALL be accepted on the first rising edge with rstn high.

Configuration
REQ-029 Macro ITER_DIVIDER_SIGNED_EN SHALL control signed support.
REQ-030 With ITER_DIVIDER_SIGNED_EN defined and signed_op=1: two's-complement operands, q truncates toward zero, r takes sign of dividend.
REQ-031 With ITER_DIVIDER_SIGNED_EN defined: MIN/-1 SHALL return q=MIN, r=0, exception=0.
REQ-032 Without ITER_DIVIDER_SIGNED_EN: signed_op port SHALL remain present but be ignored; all operations unsigned; no sign-correction logic synthesised.
REQ-033 Latency SHALL be identical in both configurations.

Verification
REQ-034 N=16, dividend=100, divisor=7 -> ready at edge 17, q=14, r=2, exception=0.
REQ-035 dividend=5, divisor=0 -> ready at edge 1, exception=1, q=0xFFFF, r=5; next 9/3 -> q=3, r=0, exception=0.
REQ-036 dividend=3, divisor=10 -> q=0, r=3; dividend=0xFFFF, divisor=1 -> q=0xFFFF, r=0.
REQ-037 Accept 100/7, drive req with 50/5 on cycles 1..16 -> single ready, q=14, r=2; busy high cycles 1..17.
REQ-038 Accept 1000/3, pull rstn low at cycle 8 for 2 cycles -> all outputs 0, no ready; then 1000/3 -> q=333, r=1.
REQ-039 SIGNED_EN, signed_op=1: -7/2 -> q=0xFFFD, r=0xFFFF; 0x8000/0xFFFF -> q=0x8000, r=0; signed_op=0 0xFFF9/2 -> q=0x7FFC, r=1.
